// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch-predictor update path.
//   BP_PC_W     : width of a branch PC
//   bp_update_t : one queued predictor update (PC plus resolved direction)
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_PC_W = 32;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
    } bp_update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
// Circular buffer that accepts up to NUM_REQ writes and at most one read per
// cycle. Writes arrive compacted: slots 0..push_cnt-1 of push_data are stored
// at tail, tail+1, ... in that order. The caller never pushes more entries
// than there is room for (including a same-cycle pop).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push_cnt   : number of valid entries in push_data this cycle
//   push_data  : compacted entries to append
//   pop        : remove the head entry
//   head       : current head entry (meaningful when count != 0)
//   count      : current occupancy
// -----------------------------------------------------------------------------
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           push_cnt,
    input  bp_update_t [NUM_REQ-1:0]   push_data,
    input  logic                       pop,
    output bp_update_t                 head,
    output logic [CNT_W-1:0]           count
);

    bp_update_t       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] waddr_s [NUM_REQ];
    logic [NUM_REQ-1:0] wen_s;

    // Per-slot write address (wraps naturally, depth is a power of two) and enable
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            waddr_s[k] = tail_r + PTR_W'(k);
            wen_s[k]   = (k < int'(push_cnt));
        end
    end

    // Entry storage; cleared on reset so stale data never reaches the head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (wen_s[k]) begin
                    mem_r[waddr_s[k]] <= push_data[k];
                end
            end
        end
    end

    // Head/tail pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            tail_r  <= tail_r + PTR_W'(push_cnt);
            head_r  <= head_r + PTR_W'(pop);
            count_r <= count_r + push_cnt - CNT_W'(pop);
        end
    end

    assign head  = mem_r[head_r];
    assign count = count_r;

endmodule

// File: rtl/bp_update_arbiter.sv
// -----------------------------------------------------------------------------
// bp_update_arbiter
// Collects resolved-branch outcomes from NUM_REQ execution ports, grants them
// in rotating priority into an update queue, and drains the queue one entry
// per cycle into the 2-bit-counter predictor update port.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_pc/req_taken : per-port update requests
//   req_ready                  : per-port combinational grant
//   upd_hold                   : stall draining
//   update_en/update_pc/actual_taken : predictor update port
//   fifo_count                 : queue occupancy
//   perf_accepted/perf_denied  : performance counters
// Build option: define BP_UPD_PERF_EN to instantiate the performance
// counters; otherwise both perf outputs are constant zero.
// -----------------------------------------------------------------------------
module bp_update_arbiter
    import bp_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][BP_PC_W-1:0]  req_pc,
    input  logic [NUM_REQ-1:0]               req_taken,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             upd_hold,
    output logic                             update_en,
    output logic [BP_PC_W-1:0]               update_pc,
    output logic                             actual_taken,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic [31:0]                      perf_accepted,
    output logic [31:0]                      perf_denied
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [CNT_W-1:0]          count_s;
    bp_update_t                head_s;
    logic                      pop_s;
    logic [CNT_W-1:0]          free_s;
    logic [CNT_W-1:0]          grant_cnt_s;
    logic [NUM_REQ-1:0]        ready_s;
    bp_update_t [NUM_REQ-1:0]  push_data_s;
    logic                      any_denied_s;
    logic [RR_W-1:0]           first_denied_s;
    logic [RR_W-1:0]           rr_ptr_r;

    // Drain whenever something is queued and the predictor is not held;
    // nothing is emitted while reset is asserted.
    assign pop_s  = (count_s != '0) && !upd_hold && !rst;
    // A same-cycle pop frees one slot for a same-cycle push
    assign free_s = CNT_W'(FIFO_DEPTH) - count_s + CNT_W'(pop_s);

    // Rotating-priority grant: valid ports are granted in scan order until the
    // free slots run out; granted entries are compacted in that same order.
    always_comb begin
        int gcnt;
        int idx;
        ready_s        = '0;
        push_data_s    = '0;
        any_denied_s   = 1'b0;
        first_denied_s = rr_ptr_r;
        gcnt           = 0;
        idx            = 0;
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr_r) + k) % NUM_REQ;
                if (req_valid[idx]) begin
                    if (gcnt < int'(free_s)) begin
                        ready_s[idx]            = 1'b1;
                        push_data_s[gcnt].pc    = req_pc[idx];
                        push_data_s[gcnt].taken = req_taken[idx];
                        gcnt                    = gcnt + 1;
                    end else if (!any_denied_s) begin
                        any_denied_s   = 1'b1;
                        first_denied_s = RR_W'(idx);
                    end else begin
                        any_denied_s = 1'b1;
                    end
                end else begin
                    ready_s[idx] = 1'b0;
                end
            end
        end else begin
            ready_s = '0;
        end
        grant_cnt_s = CNT_W'(gcnt);
    end

    assign req_ready = ready_s;

    // Priority pointer jumps to the first port that lost, so it wins next time
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (any_denied_s) begin
            rr_ptr_r <= first_denied_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    bp_update_fifo #(
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (grant_cnt_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Update port: head entry while draining, zeros otherwise
    always_comb begin
        update_en = pop_s;
        if (pop_s) begin
            update_pc    = head_s.pc;
            actual_taken = head_s.taken;
        end else begin
            update_pc    = '0;
            actual_taken = 1'b0;
        end
    end

    assign fifo_count = count_s;

`ifdef BP_UPD_PERF_EN
    logic [31:0] perf_accepted_r;
    logic [31:0] perf_denied_r;

    // Accepted entries and denial cycles; both wrap modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_accepted_r <= 32'd0;
            perf_denied_r   <= 32'd0;
        end else begin
            perf_accepted_r <= perf_accepted_r + 32'(grant_cnt_s);
            perf_denied_r   <= perf_denied_r + (any_denied_s ? 32'd1 : 32'd0);
        end
    end

    assign perf_accepted = perf_accepted_r;
    assign perf_denied   = perf_denied_r;
`else
    assign perf_accepted = 32'd0;
    assign perf_denied   = 32'd0;
`endif

endmodule

// File: tb/tb_bp_update_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_update_arbiter
// Directed bench for bp_update_arbiter (NUM_REQ=2, FIFO_DEPTH=4). Inputs are
// driven 1ns after each rising edge and outputs sampled 1ns later.
// -----------------------------------------------------------------------------
module tb_bp_update_arbiter;
    import bp_pkg::*;

`ifdef BP_UPD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_pc;
    logic [1:0]        req_taken;
    logic [1:0]        req_ready;
    logic              upd_hold;
    logic              update_en;
    logic [31:0]       update_pc;
    logic              actual_taken;
    logic [2:0]        fifo_count;
    logic [31:0]       perf_accepted;
    logic [31:0]       perf_denied;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bp_update_arbiter #(.NUM_REQ(2), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_pc        (req_pc),
        .req_taken     (req_taken),
        .req_ready     (req_ready),
        .upd_hold      (upd_hold),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .actual_taken  (actual_taken),
        .fifo_count    (fifo_count),
        .perf_accepted (perf_accepted),
        .perf_denied   (perf_denied)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_upd(input string tag, input logic en, input logic [31:0] pc,
                           input logic tk, input logic [2:0] cnt);
        chk({tag, "_en"},    32'(update_en),    32'(en));
        chk({tag, "_pc"},    update_pc,         pc);
        chk({tag, "_taken"}, 32'(actual_taken), 32'(tk));
        chk({tag, "_count"}, 32'(fifo_count),   32'(cnt));
    endtask

    initial begin
        // ---------------- reset: ready forced low while rst high ----------
        rst = 1'b1; upd_hold = 1'b0; req_valid = 2'b11;
        req_pc = '0; req_taken = 2'b00;
        #2;
        chk("rst_ready_a", 32'(req_ready), 32'd0);
        tick(); #1;
        chk("rst_ready_b", 32'(req_ready), 32'd0);
        chk_upd("rst_state", 1'b0, 32'h0, 1'b0, 3'd0);
        rst = 1'b0; req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_upd("idle", 1'b0, 32'h0, 1'b0, 3'd0);
        end
        chk("idle_perf_acc", perf_accepted, 32'd0);
        chk("idle_perf_den", perf_denied,   32'd0);

        // ---------------- single push ------------------------------------
        req_valid = 2'b01; req_pc[0] = 32'h0000_1004; req_taken = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_en_t0", 32'(update_en), 32'd0);
        tick(); req_valid = 2'b00; #1;
        chk_upd("single_t1", 1'b1, 32'h0000_1004, 1'b1, 3'd1);
        tick();
        chk_upd("single_t2", 1'b0, 32'h0, 1'b0, 3'd0);

        // ---------------- dual push into empty queue ---------------------
        req_valid = 2'b11; req_pc[0] = 32'h100; req_pc[1] = 32'h200; req_taken = 2'b10;
        #1;
        chk("dual_ready", 32'(req_ready), 32'h3);
        tick(); req_valid = 2'b00; #1;
        chk_upd("dual_t1", 1'b1, 32'h100, 1'b0, 3'd2);
        tick();
        chk_upd("dual_t2", 1'b1, 32'h200, 1'b1, 3'd1);
        tick();
        chk_upd("dual_t3", 1'b0, 32'h0, 1'b0, 3'd0);
        chk("dual_perf_acc", perf_accepted, 32'(PERF * 3));

        // ---------------- fill to 4 under hold ---------------------------
        upd_hold = 1'b1;
        req_valid = 2'b11; req_pc[0] = 32'h10; req_pc[1] = 32'h14; req_taken = 2'b01;
        #1;
        chk("fill1_ready", 32'(req_ready), 32'h3);
        tick();
        req_pc[0] = 32'h18; req_pc[1] = 32'h1C;
        #1;
        chk("fill2_ready", 32'(req_ready), 32'h3);
        chk("fill2_en",    32'(update_en), 32'd0);
        tick();

        // ---------------- full with hold: nothing moves ------------------
        req_pc[0] = 32'h30; req_pc[1] = 32'h34;
        #1;
        chk("full_ready", 32'(req_ready), 32'h0);
        chk_upd("full_hold", 1'b0, 32'h0, 1'b0, 3'd4);
        tick();
        chk("full_count_after", 32'(fifo_count), 32'd4);
        chk("full_perf_den",    perf_denied, 32'(PERF * 1));

        // ---------------- release: one grant + one pop, alternating ------
        upd_hold = 1'b0;
        #1;
        chk("rel1_ready", 32'(req_ready), 32'h1);
        chk_upd("rel1", 1'b1, 32'h10, 1'b1, 3'd4);
        tick(); req_pc[0] = 32'h38; #1;
        chk("rel2_ready", 32'(req_ready), 32'h2);
        chk_upd("rel2", 1'b1, 32'h14, 1'b0, 3'd4);
        tick(); #1;
        chk("rel3_ready", 32'(req_ready), 32'h1);
        chk_upd("rel3", 1'b1, 32'h18, 1'b1, 3'd4);
        tick(); req_valid = 2'b00; #1;
        chk("rel_perf_acc", perf_accepted, 32'(PERF * 10));
        chk("rel_perf_den", perf_denied,   32'(PERF * 4));
        // drain: 0x1C, then port0 0x30, port1 0x34, port0 0x38
        chk_upd("drain1", 1'b1, 32'h1C, 1'b0, 3'd4);
        tick();
        chk_upd("drain2", 1'b1, 32'h30, 1'b1, 3'd3);
        tick();
        chk_upd("drain3", 1'b1, 32'h34, 1'b0, 3'd2);
        tick();
        chk_upd("drain4", 1'b1, 32'h38, 1'b1, 3'd1);
        tick();
        chk_upd("drain5", 1'b0, 32'h0, 1'b0, 3'd0);

        // ---------------- rotated scan order (priority now at port1) -----
        req_valid = 2'b11; req_pc[0] = 32'h50; req_pc[1] = 32'h54; req_taken = 2'b01;
        #1;
        chk("rot_ready", 32'(req_ready), 32'h3);
        tick(); req_valid = 2'b00; #1;
        chk_upd("rot_t1", 1'b1, 32'h54, 1'b0, 3'd2);
        tick();
        chk_upd("rot_t2", 1'b1, 32'h50, 1'b1, 3'd1);
        tick();
        chk_upd("rot_t3", 1'b0, 32'h0, 1'b0, 3'd0);

        // ---------------- mid-operation reset ----------------------------
        upd_hold = 1'b1;
        req_valid = 2'b11; req_pc[0] = 32'h40; req_pc[1] = 32'h44;
        tick();
        req_valid = 2'b01; req_pc[0] = 32'h48;
        tick(); req_valid = 2'b00; #1;
        chk("mid_count3",   32'(fifo_count), 32'd3);
        chk("mid_perf_acc", perf_accepted,   32'(PERF * 15));
        rst = 1'b1;
        tick();
        rst = 1'b0; upd_hold = 1'b0; #1;
        chk_upd("post_rst", 1'b0, 32'h0, 1'b0, 3'd0);
        chk("post_rst_perf_acc", perf_accepted, 32'd0);
        chk("post_rst_perf_den", perf_denied,   32'd0);
        tick();
        chk_upd("post_rst2", 1'b0, 32'h0, 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
